// File: rtl/sw_input_pkg.sv
// Shared register addresses, ID constant and read-FSM state type for the switch input port.
package sw_input_pkg;

    localparam logic [1:0] ADDR_STATE = 2'd0;
    localparam logic [1:0] ADDR_RISE  = 2'd1;
    localparam logic [1:0] ADDR_FALL  = 2'd2;
    localparam logic [1:0] ADDR_ID    = 2'd3;

    localparam logic [31:0] SW_ID = 32'h5357_0001;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } rd_state_t;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, debounce counter, stable level and update pulses.
// A clean change reaches stable 2+DEBOUNCE_CYCLES cycles later; rise/fall pulse in the update cycle.
module sw_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic sw,
    output logic stable,
    output logic rise,
    output logic fall
);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;
    logic             upd;

    // Accept the new level on the last cycle of an unbroken mismatch run.
    assign upd  = (sync_b != stable) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign rise = upd & sync_b;
    assign fall = upd & ~sync_b;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_a <= sw;
            sync_b <= sync_a;
            if (sync_b == stable) begin
                cnt <= '0;
            end else if (upd) begin
                stable <= sync_b;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_input_port.sv
// Slide-switch read port: debounced state plus sticky edge flags, read via req/ack (ack 2 cycles after req, one read per 2 cycles).
// Optional SW_INPUT_PORT_IRQ_EN adds sw_irq and turns address 3 into a fixed all-ones IRQ_MASK.
module sw_input_port
    import sw_input_pkg::*;
#(
    parameter int SW_W            = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [SW_W-1:0] SW,
    input  logic            rd_req,
    input  logic [1:0]      rd_addr,
    output logic            rd_ack,
    output logic [31:0]     rd_data
`ifdef SW_INPUT_PORT_IRQ_EN
    ,
    output logic            sw_irq
`endif
);

    logic [SW_W-1:0] stable;
    logic [SW_W-1:0] rise_p;
    logic [SW_W-1:0] fall_p;
    logic [SW_W-1:0] rise_q;
    logic [SW_W-1:0] fall_q;
    logic [SW_W-1:0] clr_rise;
    logic [SW_W-1:0] clr_fall;
    logic [31:0]     sel_data;
    logic [1:0]      addr_q;
    rd_state_t       state;

    for (genvar i = 0; i < SW_W; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .CLK   (CLK),
            .RST   (RST),
            .sw    (SW[i]),
            .stable(stable[i]),
            .rise  (rise_p[i]),
            .fall  (fall_p[i])
        );
    end

    always_comb begin
        sel_data = '0;
        case (addr_q)
            ADDR_STATE: sel_data = 32'(stable);
            ADDR_RISE:  sel_data = 32'(rise_q);
            ADDR_FALL:  sel_data = 32'(fall_q);
`ifdef SW_INPUT_PORT_IRQ_EN
            default:    sel_data = 32'({SW_W{1'b1}});
`else
            default:    sel_data = SW_ID;
`endif
        endcase
    end

    // Only the bits handed out in this read are cleared; a same-cycle edge still wins.
    always_comb begin
        clr_rise = '0;
        clr_fall = '0;
        if (state == RESP) begin
            if (addr_q == ADDR_RISE) clr_rise = rise_q;
            if (addr_q == ADDR_FALL) clr_fall = fall_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= (rise_q & ~clr_rise) | rise_p;
            fall_q <= (fall_q & ~clr_fall) | fall_p;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= IDLE;
            addr_q  <= '0;
            rd_ack  <= 1'b0;
            rd_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rd_ack  <= 1'b0;
                    rd_data <= '0;
                    if (rd_req) begin
                        addr_q <= rd_addr;
                        state  <= RESP;
                    end
                end
                default: begin
                    rd_ack  <= 1'b1;
                    rd_data <= sel_data;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef SW_INPUT_PORT_IRQ_EN
    always_ff @(posedge CLK) begin
        if (!RST) sw_irq <= 1'b0;
        else      sw_irq <= |(rise_q | fall_q);
    end
`endif

endmodule

// File: tb/tb_sw_input_port.sv
// Bench for sw_input_port with DEBOUNCE_CYCLES=4: directed scenarios plus a randomized run
// checked against a window-based reference model of the switch port.
module tb_sw_input_port;

    localparam int SW_W = 4;
    localparam int D    = 4;
`ifdef SW_INPUT_PORT_IRQ_EN
    localparam logic [31:0] EXP3 = 32'h0000_000F;
`else
    localparam logic [31:0] EXP3 = 32'h5357_0001;
`endif

    logic            CLK;
    logic            RST;
    logic [SW_W-1:0] SW;
    logic            rd_req;
    logic [1:0]      rd_addr;
    logic            rd_ack;
    logic [31:0]     rd_data;
`ifdef SW_INPUT_PORT_IRQ_EN
    logic            sw_irq;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rdat;
    logic [31:0] mdat;
    logic        rok;

    sw_input_port #(
        .SW_W           (SW_W),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (16)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .SW     (SW),
        .rd_req (rd_req),
        .rd_addr(rd_addr),
        .rd_ack (rd_ack),
        .rd_data(rd_data)
`ifdef SW_INPUT_PORT_IRQ_EN
        ,
        .sw_irq (sw_irq)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: a bit's accepted level flips when the switch level seen two
    // edges ago, and on the D-1 edges before that, all disagree with the accepted level.
    logic [SW_W-1:0] hist[$];
    logic [SW_W-1:0] m_stable, m_rise, m_fall;
    logic            m_busy;
    logic [1:0]      m_addr;
    logic            m_ack;
    logic [31:0]     m_data;

    always @(posedge CLK) begin
        logic [SW_W-1:0] nxt, set_r, set_f, clr_r, clr_f;
        logic            all_diff;
        if (!RST) begin
            hist.delete();
            for (int k = 0; k < D + 2; k++) hist.push_back('0);
            m_stable = '0;
            m_rise   = '0;
            m_fall   = '0;
            m_busy   = 1'b0;
            m_addr   = '0;
            m_ack    = 1'b0;
            m_data   = '0;
        end else begin
            hist.push_back(SW);
            if (hist.size() > 32) void'(hist.pop_front());
            nxt = m_stable;
            for (int b = 0; b < SW_W; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++)
                    if (hist[hist.size() - 3 - j][b] == m_stable[b]) all_diff = 1'b0;
                if (all_diff) nxt[b] = ~m_stable[b];
            end
            set_r = nxt & ~m_stable;
            set_f = ~nxt & m_stable;
            clr_r = '0;
            clr_f = '0;
            if (m_busy) begin
                m_ack  = 1'b1;
                m_busy = 1'b0;
                case (m_addr)
                    2'd0: m_data = 32'(m_stable);
                    2'd1: begin m_data = 32'(m_rise); clr_r = m_rise; end
                    2'd2: begin m_data = 32'(m_fall); clr_f = m_fall; end
                    default: m_data = EXP3;
                endcase
            end else begin
                m_ack  = 1'b0;
                m_data = '0;
                if (rd_req) begin
                    m_busy = 1'b1;
                    m_addr = rd_addr;
                end
            end
            m_rise   = (m_rise & ~clr_r) | set_r;
            m_fall   = (m_fall & ~clr_f) | set_f;
            m_stable = nxt;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Issues one read; bounded wait for the ack, returning DUT data and model data.
    task automatic do_read(input logic [1:0] a);
        @(negedge CLK);
        rd_req  = 1'b1;
        rd_addr = a;
        @(negedge CLK);
        rd_req = 1'b0;
        rok  = 1'b0;
        rdat = '0;
        mdat = '0;
        for (int i = 0; i < 4 && !rok; i++) begin
            @(negedge CLK);
            if (rd_ack) begin
                rok  = 1'b1;
                rdat = rd_data;
                mdat = m_data;
            end
        end
    endtask

    task automatic test_reset;
        RST = 1'b0;
        SW  = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_checks++;
            if (rd_ack !== 1'b0 || rd_data !== 32'h0) begin
                n_errors++;
                $display("FAIL reset_outputs: ack=%b data=%h, required ack=0 data=0", rd_ack, rd_data);
            end
        end
        RST = 1'b1;
        do_read(2'd0);
        n_checks++;
        if (!rok || rdat !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_state: ack=%b data=%h, required 00000000", rok, rdat);
        end
        wait_cycles(6);
        do_read(2'd0);
        n_checks++;
        if (!rok || rdat !== 32'h0000_000F || rdat !== mdat) begin
            n_errors++;
            $display("FAIL settle_state: data=%h, required 0000000f (model %h)", rdat, mdat);
        end
        do_read(2'd1);
        n_checks++;
        if (!rok || rdat !== 32'h0000_000F || rdat !== mdat) begin
            n_errors++;
            $display("FAIL settle_rise: data=%h, required 0000000f (model %h)", rdat, mdat);
        end
    endtask

    task automatic test_glitch;
        SW = 4'h0;
        wait_cycles(8);
        do_read(2'd2);
        n_checks++;
        if (!rok || rdat !== 32'h0000_000F) begin
            n_errors++;
            $display("FAIL fall_all: data=%h, required 0000000f", rdat);
        end
        do_read(2'd1);
        n_checks++;
        if (!rok || rdat !== 32'h0) begin
            n_errors++;
            $display("FAIL rise_cleared: data=%h, required 00000000", rdat);
        end
        @(negedge CLK);
        SW = 4'h1;
        wait_cycles(3);
        SW = 4'h0;
        wait_cycles(8);
        do_read(2'd0);
        n_checks++;
        if (!rok || rdat !== 32'h0 || rdat !== mdat) begin
            n_errors++;
            $display("FAIL glitch_state: data=%h, required 00000000 (model %h)", rdat, mdat);
        end
        do_read(2'd1);
        n_checks++;
        if (!rok || rdat !== 32'h0 || rdat !== mdat) begin
            n_errors++;
            $display("FAIL glitch_rise: data=%h, required 00000000 (model %h)", rdat, mdat);
        end
    endtask

    task automatic test_read_clear;
        @(negedge CLK);
        SW = 4'h4;
        wait_cycles(8);
        do_read(2'd1);
        n_checks++;
        if (!rok || rdat !== 32'h4) begin
            n_errors++;
            $display("FAIL rc_rise_first: data=%h, required 00000004", rdat);
        end
        do_read(2'd1);
        n_checks++;
        if (!rok || rdat !== 32'h0) begin
            n_errors++;
            $display("FAIL rc_rise_second: data=%h, required 00000000", rdat);
        end
        do_read(2'd2);
        n_checks++;
        if (!rok || rdat !== 32'h0) begin
            n_errors++;
            $display("FAIL rc_fall: data=%h, required 00000000", rdat);
        end
    endtask

    task automatic test_race;
        @(negedge CLK);
        SW = 4'h2;
        wait_cycles(8);
        do_read(2'd1);
        n_checks++;
        if (!rok || rdat !== 32'h2) begin
            n_errors++;
            $display("FAIL race_setup_rise: data=%h, required 00000002", rdat);
        end
        do_read(2'd2);
        n_checks++;
        if (!rok || rdat !== 32'h4) begin
            n_errors++;
            $display("FAIL race_setup_fall: data=%h, required 00000004", rdat);
        end
        // SW[1] falls before edge t0; its stable update lands on edge t0+5 = RESP edge.
        @(negedge CLK);
        SW = 4'h0;
        repeat (4) @(posedge CLK);
        do_read(2'd2);
        n_checks++;
        if (!rok || rdat !== 32'h0 || rdat !== mdat) begin
            n_errors++;
            $display("FAIL race_first: data=%h, required 00000000 (model %h)", rdat, mdat);
        end
        do_read(2'd2);
        n_checks++;
        if (!rok || rdat !== 32'h2 || rdat !== mdat) begin
            n_errors++;
            $display("FAIL race_second: data=%h, required 00000002 (model %h)", rdat, mdat);
        end
    endtask

    task automatic test_back_to_back;
        int acks;
        acks = 0;
        @(negedge CLK);
        rd_req  = 1'b1;
        rd_addr = 2'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            n_checks++;
            if (rd_ack) begin
                acks++;
                if (rd_data !== EXP3) begin
                    n_errors++;
                    $display("FAIL b2b_data: cycle %0d data=%h, required %h", i, rd_data, EXP3);
                end
            end else if (rd_data !== 32'h0) begin
                n_errors++;
                $display("FAIL b2b_idle_data: cycle %0d data=%h, required 00000000", i, rd_data);
            end
            if (i == 5) rd_req = 1'b0;
        end
        n_checks++;
        if (acks != 3) begin
            n_errors++;
            $display("FAIL b2b_ack_count: got %0d, required 3", acks);
        end
    endtask

    task automatic test_reset_mid_read;
        @(negedge CLK);
        SW = 4'h1;
        wait_cycles(8);
`ifdef SW_INPUT_PORT_IRQ_EN
        n_checks++;
        if (sw_irq !== 1'b1) begin
            n_errors++;
            $display("FAIL irq_set: sw_irq=%b, required 1", sw_irq);
        end
`endif
        rd_req  = 1'b1;
        rd_addr = 2'd1;
        @(negedge CLK);
        RST    = 1'b0;
        rd_req = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (rd_ack !== 1'b0 || rd_data !== 32'h0) begin
            n_errors++;
            $display("FAIL midreset_ack: ack=%b data=%h, required ack=0 data=0", rd_ack, rd_data);
        end
        RST = 1'b1;
        do_read(2'd1);
        n_checks++;
        if (!rok || rdat !== 32'h0) begin
            n_errors++;
            $display("FAIL midreset_rise: data=%h, required 00000000", rdat);
        end
`ifdef SW_INPUT_PORT_IRQ_EN
        n_checks++;
        if (sw_irq !== 1'b0) begin
            n_errors++;
            $display("FAIL irq_reset: sw_irq=%b, required 0", sw_irq);
        end
`endif
    endtask

    task automatic test_random;
        for (int it = 0; it < 120; it++) begin
            @(negedge CLK);
            if ($urandom_range(0, 2) == 0) SW = SW ^ (4'b1 << $urandom_range(0, SW_W - 1));
            else if ($urandom_range(0, 3) == 0) SW = 4'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                do_read(2'($urandom_range(0, 3)));
                n_checks++;
                if (!rok || rdat !== mdat) begin
                    n_errors++;
                    $display("FAIL random_read: it %0d ack=%b data=%h, required %h", it, rok, rdat, mdat);
                end
            end else begin
                wait_cycles($urandom_range(1, 7));
            end
        end
    endtask

    initial begin
        RST     = 1'b0;
        SW      = '0;
        rd_req  = 1'b0;
        rd_addr = '0;
        test_reset;
        test_glitch;
        test_read_clear;
        test_race;
        test_back_to_back;
        test_reset_mid_read;
        test_random;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/sw_input_port.md
Name: sw_input_port

Overview:
- Input-side peripheral for the RISC-V system: the read path for the board slide switches SW, the counterpart to the HEX0 display output path.
- Synchronises and debounces each switch, records rising and falling edges in sticky flags, and presents state and flags to the core through a simple request/acknowledge read bus.
- Sits beside the core in risc_v_under_top; the core polls it through its load path.

Parameters:
- SW_W, 4, number of switch inputs.
- DEBOUNCE_CYCLES, 50000, cycles a synchronised level must stay stable before it is accepted (1 ms at 50 MHz). Minimum 2.
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  reset, synchronous, active-low; sampled only on the CLK rising edge.
- SW  in  SW_W  raw asynchronous switch levels.
- rd_req  in  1  read request, qualified by rd_addr.
- rd_addr  in  2  register select.
- rd_ack  out  1  one-cycle pulse; rd_data is valid in that cycle.
- rd_data  out  32  read data; zero whenever rd_ack is 0.

Behaviour:
- Reset state (RST==0 at a clock edge):
  - Synchroniser flops, stable state, counters, rise/fall flags, rd_ack and rd_data all go to 0.
  - FSM goes to IDLE.
  - This applies mid-transaction too: a pending ack is dropped and no ack is issued for it.
- Synchroniser: two flops per bit give sync[i].
- Debounce, per bit:
  - If sync[i]==stable[i], cnt[i] is cleared to 0.
  - Otherwise cnt[i] increments. When cnt[i]==DEBOUNCE_CYCLES-1 and the levels still differ, stable[i] takes sync[i] and cnt[i] clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
  - Latency from a clean SW change to stable update is 2+DEBOUNCE_CYCLES cycles.
- Edge flags:
  - rise[i] sets on a stable 0->1 update; fall[i] sets on a stable 1->0 update.
  - Both are sticky until read.
- Register map (rd_data, zero-extended):
  - 0 STATE: stable[SW_W-1:0].
  - 1 RISE: rise flags; read clears them.
  - 2 FALL: fall flags; read clears them.
  - 3 ID: constant 32'h5357_0001.
- Read FSM:
  - IDLE: when rd_req==1, capture rd_addr and go to RESP.
  - RESP: rd_ack=1 and rd_data = the selected value, sampled at the RESP edge. Return to IDLE.
  - rd_req is ignored while in RESP. A request held high is serviced again, so back-to-back reads complete at most once every 2 cycles.
- Read-clear:
  - Applies at the edge ending RESP, only for the flag bits returned in that read.
  - If an edge sets a flag in the same cycle it is being cleared, set wins: the flag stays 1 and the read returns the old value.
- Simultaneous rise and fall on the same bit cannot occur, since stable changes at most once per DEBOUNCE_CYCLES.

Optional Feature:
- Macro: SW_INPUT_PORT_IRQ_EN.
- Defined:
  - Adds output port sw_irq (1 bit) = OR of all rise and fall flags, registered, reset 0.
  - Adds register 3 as IRQ_MASK (write-less, fixed all-ones); the ID moves to an internal constant only.
  - sw_irq deasserts the cycle after the last flag clears.
- Not defined: no sw_irq port, and address 3 returns the ID.

Decomposition:
- Package sw_input_pkg holds:
  - address constants ADDR_STATE=0, ADDR_RISE=1, ADDR_FALL=2, ADDR_ID=3;
  - SW_ID=32'h5357_0001;
  - read FSM state enum {IDLE, RESP}.
- Sub-module sw_debounce_bit (synchroniser + counter + stable + edge pulses):
  - instantiated SW_W times via generate;
  - flags and bus FSM stay in the top.

Test Plan (DEBOUNCE_CYCLES=4 in sim):
- Reset: hold RST=0 for 3 cycles with SW=4'hF -> STATE reads 0, rd_ack=0; release reset, then after 6 cycles STATE reads 32'h0000_000F and RISE reads 32'h0000_000F.
- Glitch: SW[0] high for 3 cycles, then low -> STATE stays 0 and RISE stays 0.
- Read-clear: SW[2] 0->1 and settles -> RISE reads 32'h4; the immediately following RISE read returns 0; FALL reads 0.
- Set vs clear race: align a SW[1] stable falling update with the RESP edge of a FALL read -> that read returns 0, and the next FALL read returns 32'h2.
- Handshake: rd_req held high for 6 cycles at addr 3 -> exactly 3 rd_ack pulses, each with rd_data=32'h5357_0001; rd_data=0 between pulses.
- Reset mid-read: drive RST=0 in the RESP cycle -> no rd_ack on the following edge; flags cleared.
